// File: rtl/ascon_pkg.sv
// Shared constants, S-box tables and FSM encoding for the Ascon permutation cores.
// Rows are x0..x4 from the top of the 320-bit state downward.
package ascon_pkg;

  localparam int STATE_W    = 320;
  localparam int ROW_W      = 64;
  localparam int MAX_ROUNDS = 12;
  localparam int LSTEPS     = 63;

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINV = 2'd1,
    ST_SINV = 2'd2,
    ST_DONE = 2'd3
  } fsm_t;

  function automatic logic [ROW_W-1:0] rotr64(input logic [ROW_W-1:0] x, input int n);
    return (x >> n) | (x << (ROW_W - n));
  endfunction

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    case (x)
      5'h00: return 5'h04; 5'h01: return 5'h0b; 5'h02: return 5'h1f; 5'h03: return 5'h14;
      5'h04: return 5'h1a; 5'h05: return 5'h15; 5'h06: return 5'h09; 5'h07: return 5'h02;
      5'h08: return 5'h1b; 5'h09: return 5'h05; 5'h0a: return 5'h08; 5'h0b: return 5'h12;
      5'h0c: return 5'h1d; 5'h0d: return 5'h03; 5'h0e: return 5'h06; 5'h0f: return 5'h1c;
      5'h10: return 5'h1e; 5'h11: return 5'h13; 5'h12: return 5'h07; 5'h13: return 5'h0e;
      5'h14: return 5'h00; 5'h15: return 5'h0d; 5'h16: return 5'h11; 5'h17: return 5'h18;
      5'h18: return 5'h10; 5'h19: return 5'h0c; 5'h1a: return 5'h01; 5'h1b: return 5'h19;
      5'h1c: return 5'h16; 5'h1d: return 5'h0a; 5'h1e: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    case (x)
      5'h00: return 5'h14; 5'h01: return 5'h1a; 5'h02: return 5'h07; 5'h03: return 5'h0d;
      5'h04: return 5'h00; 5'h05: return 5'h09; 5'h06: return 5'h0e; 5'h07: return 5'h12;
      5'h08: return 5'h0a; 5'h09: return 5'h06; 5'h0a: return 5'h1d; 5'h0b: return 5'h01;
      5'h0c: return 5'h19; 5'h0d: return 5'h15; 5'h0e: return 5'h13; 5'h0f: return 5'h1e;
      5'h10: return 5'h18; 5'h11: return 5'h16; 5'h12: return 5'h0b; 5'h13: return 5'h11;
      5'h14: return 5'h03; 5'h15: return 5'h05; 5'h16: return 5'h1c; 5'h17: return 5'h1f;
      5'h18: return 5'h17; 5'h19: return 5'h1b; 5'h1a: return 5'h04; 5'h1b: return 5'h08;
      5'h1c: return 5'h0f; 5'h1d: return 5'h0c; 5'h1e: return 5'h10; default: return 5'h02;
    endcase
  endfunction

endpackage

// File: rtl/ascon_linear.sv
// Forward Ascon linear diffusion layer: each row x ^= rotr(x,a) ^ rotr(x,b).
// Purely combinational; the inverse core applies it LSTEPS times per round.
module ascon_linear
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] d,
  output logic [STATE_W-1:0] q
);

  for (genvar r = 0; r < 5; r++) begin : g_row
    localparam int HI = STATE_W - 1 - r * ROW_W;
    logic [ROW_W-1:0] x;
    assign x         = d[HI -: ROW_W];
    assign q[HI -: ROW_W] = x ^ rotr64(x, ROT_A[r]) ^ rotr64(x, ROT_B[r]);
  end

endmodule

// File: rtl/ascon_perm_inv.sv
// Iterative inverse Ascon permutation: per round, 63 forward-L steps (= L^-1),
// then inverse S-box columns plus round-constant removal in one cycle.
module ascon_perm_inv
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_s,
  input  logic [3:0]         in_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_s,
  output logic               busy,
  output fsm_t               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; in_ready depends only on the FSM, out_valid is a flop, neither looks at the other side.

  fsm_t               fsm, fsm_next;
  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] lin_q;
  logic [STATE_W-1:0] sinv_s;
  logic [3:0]         rnd, rc, rnd_clamped;
  logic [5:0]         step;
  logic [4:0]         col, icol;

  ascon_linear u_linear (
    .d (st),
    .q (lin_q)
  );

  assign rnd_clamped = (in_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : in_rounds;
  assign in_ready    = (fsm == ST_IDLE);
  assign busy        = (fsm == ST_LINV) || (fsm == ST_SINV);
  assign dbg_state   = fsm;

  always_comb begin
    sinv_s = st;
    col    = '0;
    icol   = '0;
    for (int i = 0; i < ROW_W; i++) begin
      col  = {st[4*ROW_W+i], st[3*ROW_W+i], st[2*ROW_W+i], st[ROW_W+i], st[i]};
      icol = sbox_inv(col);
      sinv_s[4*ROW_W+i] = icol[4];
      sinv_s[3*ROW_W+i] = icol[3];
      sinv_s[2*ROW_W+i] = icol[2];
      sinv_s[ROW_W+i]   = icol[1];
      sinv_s[i]         = icol[0];
    end
    // Round constant sits in the low byte of x2, added after the S-box is undone.
    sinv_s[2*ROW_W+7 -: 8] = sinv_s[2*ROW_W+7 -: 8] ^ {~rc, rc};
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      ST_IDLE: if (in_valid) fsm_next = (rnd_clamped != 4'd0) ? ST_LINV : ST_DONE;
      ST_LINV: if (step == 6'(LSTEPS - 1)) fsm_next = ST_SINV;
      ST_SINV: fsm_next = (rnd == 4'd1) ? ST_DONE : ST_LINV;
      ST_DONE: if (out_ready) fsm_next = ST_IDLE;
      default: fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      st        <= '0;
      rnd       <= '0;
      rc        <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      out_s     <= '0;
    end else begin
      fsm <= fsm_next;
      case (fsm)
        ST_IDLE: if (in_valid) begin
          st   <= in_s;
          rnd  <= rnd_clamped;
          rc   <= 4'd11;
          step <= '0;
          if (rnd_clamped == 4'd0) begin
            out_valid <= 1'b1;
            out_s     <= in_s;
          end
        end
        ST_LINV: begin
          st   <= lin_q;
          step <= step + 6'd1;
        end
        ST_SINV: begin
          st   <= sinv_s;
          rnd  <= rnd - 4'd1;
          rc   <= rc - 4'd1;
          step <= '0;
          if (rnd == 4'd1) begin
            out_valid <= 1'b1;
            out_s     <= sinv_s;
          end
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
